// File: rtl/seq_detect_pkg.sv
// rtl/seq_detect_pkg.sv - shared state encodings and step-result type for the 1101 detector
package seq_detect_pkg;

   typedef logic [2:0] seq_state_t;

   localparam seq_state_t S0 = 3'd0;
   localparam seq_state_t S1 = 3'd1;
   localparam seq_state_t S2 = 3'd2;
   localparam seq_state_t S3 = 3'd3;

   typedef struct packed {
      seq_state_t next_state;
      logic       match;
   } step_res_t;

endpackage

// File: rtl/seq_step_1101.sv
// rtl/seq_step_1101.sv - combinational 1101 step function; SEQDET_OVERLAP_EN keeps the trailing 1 on match
module seq_step_1101
   import seq_detect_pkg::*;
(
   input  seq_state_t state_i,
   input  logic       bit_i,
   output step_res_t  res_o
);

   always_comb begin
      res_o.next_state = S0;
      res_o.match      = 1'b0;
      case (state_i)
         S0: res_o.next_state = bit_i ? S1 : S0;
         S1: res_o.next_state = bit_i ? S2 : S0;
         S2: res_o.next_state = bit_i ? S2 : S3;
         S3: begin
            if (bit_i) begin
               res_o.match = 1'b1;
`ifdef SEQDET_OVERLAP_EN
               res_o.next_state = S1;
`else
               res_o.next_state = S0;
`endif
            end
         end
         default: res_o.next_state = S0;
      endcase
   end

endmodule

// File: rtl/seq_detect_scheduler.sv
// rtl/seq_detect_scheduler.sv - one 1101 step engine shared round-robin across NUM_CH serial channels
// Match overlap behaviour follows SEQDET_OVERLAP_EN (see seq_step_1101).
module seq_detect_scheduler
   import seq_detect_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CH_W   = $clog2(NUM_CH),
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] ch_valid,
   input  logic [NUM_CH-1:0] ch_din,
   output logic [NUM_CH-1:0] ch_ready,
   input  logic [NUM_CH-1:0] ch_flush,
   output logic              det_valid,
   output logic [CH_W-1:0]   det_ch,
   output logic [CNT_W-1:0]  match_cnt
);

   seq_state_t       ctx_q [NUM_CH];
   logic [CH_W-1:0]  ptr_q, ptr_d;
   logic             det_valid_q, det_valid_d;
   logic [CH_W-1:0]  det_ch_q, det_ch_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             hi_found, lo_found, gnt_valid;
   logic [CH_W-1:0]  hi_idx, lo_idx, gnt_idx;
   step_res_t        step;
   logic             hit;

   // Descending scan leaves the lowest valid index at/after ptr in hi_idx, else lowest overall in lo_idx.
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (ch_valid[k]) begin
            if (CH_W'(k) >= ptr_q) begin
               hi_found = 1'b1;
               hi_idx   = CH_W'(k);
            end else begin
               lo_found = 1'b1;
               lo_idx   = CH_W'(k);
            end
         end
      end
      gnt_valid = hi_found | lo_found;
      gnt_idx   = hi_found ? hi_idx : lo_idx;
      ch_ready  = '0;
      if (gnt_valid) ch_ready[gnt_idx] = 1'b1;
   end

   seq_step_1101 u_step (
      .state_i (ctx_q[gnt_idx]),
      .bit_i   (ch_din[gnt_idx]),
      .res_o   (step)
   );

   // A flush on the granted channel swallows the bit, so it can never report a match.
   always_comb begin
      hit         = gnt_valid & step.match & ~ch_flush[gnt_idx];
      det_valid_d = hit;
      det_ch_d    = hit ? gnt_idx : det_ch_q;
      cnt_d       = (hit && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
      ptr_d       = ptr_q;
      if (gnt_valid) ptr_d = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NUM_CH; k++) ctx_q[k] <= S0;
         ptr_q       <= '0;
         det_valid_q <= 1'b0;
         det_ch_q    <= '0;
         cnt_q       <= '0;
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (ch_flush[k]) begin
               ctx_q[k] <= S0;
            end else if (gnt_valid && (gnt_idx == CH_W'(k))) begin
               ctx_q[k] <= step.next_state;
            end
         end
         ptr_q       <= ptr_d;
         det_valid_q <= det_valid_d;
         det_ch_q    <= det_ch_d;
         cnt_q       <= cnt_d;
      end
   end

   assign det_valid = det_valid_q;
   assign det_ch    = det_ch_q;
   assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// tb/tb_seq_detect_scheduler.sv - directed bench with suffix-history model; honours SEQDET_OVERLAP_EN
module tb_seq_detect_scheduler;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [N-1:0] ch_valid = '0, ch_din = '0, ch_flush = '0;
   logic [N-1:0] ch_ready, ch_ready_s;
   logic         det_valid, det_valid_s;
   logic [1:0]   det_ch, det_ch_s;
   logic [15:0]  match_cnt;
   logic [1:0]   match_cnt_s;

   int n_tests = 0;
   int n_fail  = 0;

   int m_ptr = 0;
   int m_cnt = 0;
   int hist [N];
   int hlen [N];
   bit e_dv = 1'b0;
   int e_ch = 0;

   seq_detect_scheduler #(.NUM_CH(N), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .ch_valid(ch_valid), .ch_din(ch_din), .ch_ready(ch_ready),
      .ch_flush(ch_flush), .det_valid(det_valid), .det_ch(det_ch), .match_cnt(match_cnt)
   );

   seq_detect_scheduler #(.NUM_CH(N), .CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .ch_valid(ch_valid), .ch_din(ch_din), .ch_ready(ch_ready_s),
      .ch_flush(ch_flush), .det_valid(det_valid_s), .det_ch(det_ch_s), .match_cnt(match_cnt_s)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Model: a channel matches when the bits received since its last clear end in 1101.
   task automatic model_step();
      int g;
      logic [N-1:0] exp_rdy;
      if (reset) begin
         m_ptr = 0;
         m_cnt = 0;
         e_dv  = 1'b0;
         for (int k = 0; k < N; k++) begin
            hist[k] = 0;
            hlen[k] = 0;
         end
         check("rst_det_ch", det_ch, 0);
      end
      g = -1;
      for (int i = 0; i < N; i++) begin
         if (g < 0 && ch_valid[(m_ptr + i) % N]) g = (m_ptr + i) % N;
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("ch_ready", ch_ready, exp_rdy);
      check("det_valid", det_valid, e_dv);
      if (e_dv) check("det_ch", det_ch, e_ch);
      check("match_cnt", match_cnt, (m_cnt > 65535) ? 65535 : m_cnt);
      check("sat_cnt", match_cnt_s, (m_cnt > 3) ? 3 : m_cnt);
      if (!reset) begin
         e_dv = 1'b0;
         if (g >= 0) begin
            if (!ch_flush[g]) begin
               hist[g] = ((hist[g] << 1) | int'(ch_din[g])) & 15;
               hlen[g]++;
               if (hlen[g] >= 4 && hist[g] == 13) begin
                  e_dv = 1'b1;
                  e_ch = g;
                  m_cnt++;
`ifdef SEQDET_OVERLAP_EN
                  hist[g] = 1;
                  hlen[g] = 1;
`else
                  hist[g] = 0;
                  hlen[g] = 0;
`endif
               end
            end
            m_ptr = (g + 1) % N;
         end
         for (int k = 0; k < N; k++) begin
            if (ch_flush[k]) begin
               hist[k] = 0;
               hlen[k] = 0;
            end
         end
      end
   endtask

   task automatic cyc(input logic r, input logic [N-1:0] v, input logic [N-1:0] d, input logic [N-1:0] f);
      @(posedge clk);
      #1;
      reset    = r;
      ch_valid = v;
      ch_din   = d;
      ch_flush = f;
      #1;
      model_step();
   endtask

   logic [N-1:0] t2_v [8] = '{4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0100};
   logic [N-1:0] t2_d [8] = '{4'b0110, 4'b0110, 4'b0110, 4'b0100, 4'b0000, 4'b0010, 4'b0110, 4'b0100};
   logic [N-1:0] t3_d [4] = '{4'b1101, 4'b1011, 4'b1110, 4'b0000};
   logic         t5_b [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

   initial begin
      int served [N];
      int npulse;
      logic [N-1:0] one;
      one = 4'b0001;

      cyc(1'b1, '0, '0, '0);
      cyc(1'b1, '0, '0, '0);
      cyc(1'b0, '0, '0, '0);
      check("reset_det_valid", det_valid, 0);
      check("reset_cnt", match_cnt, 0);

      // Channel 0 alone: 1101.
      cyc(1'b0, 4'b0001, 4'b0001, '0);
      check("t1_ready", ch_ready, 4'b0001);
      cyc(1'b0, 4'b0001, 4'b0001, '0);
      cyc(1'b0, 4'b0001, 4'b0000, '0);
      cyc(1'b0, 4'b0001, 4'b0001, '0);
      cyc(1'b0, '0, '0, '0);
      check("t1_det_valid", det_valid, 1);
      check("t1_det_ch", det_ch, 0);
      check("t1_cnt", match_cnt, 1);

      // Channels 1 and 2 interleaved, each holding its bit until granted.
      for (int i = 0; i < 8; i++) begin
         cyc(1'b0, t2_v[i], t2_d[i], '0);
         check("t2_ready", ch_ready, (i % 2 == 0) ? 4'b0010 : 4'b0100);
         if (i == 7) begin
            check("t2_det_ch1_valid", det_valid, 1);
            check("t2_det_ch1", det_ch, 1);
         end
      end
      cyc(1'b0, '0, '0, '0);
      check("t2_det_ch2_valid", det_valid, 1);
      check("t2_det_ch2", det_ch, 2);
      check("t2_cnt", match_cnt, 3);

      // Park ptr at 0, then all channels valid for 16 cycles.
      cyc(1'b0, 4'b1000, '0, '0);
      for (int k = 0; k < N; k++) served[k] = 0;
      for (int i = 0; i < 16; i++) begin
         cyc(1'b0, 4'b1111, t3_d[i / 4], '0);
         check("t3_rr_ready", ch_ready, one << (i % 4));
         for (int k = 0; k < N; k++) served[k] += int'(ch_ready[k]);
      end
      for (int k = 0; k < N; k++) check("t3_served", served[k], 4);
      cyc(1'b0, '0, '0, 4'b1111);

      // Channel 3: 110, then flush colliding with a granted 1.
      cyc(1'b0, 4'b1000, 4'b1000, '0);
      cyc(1'b0, 4'b1000, 4'b1000, '0);
      cyc(1'b0, 4'b1000, 4'b0000, '0);
      cyc(1'b0, 4'b1000, 4'b1000, 4'b1000);
      check("t4_flush_ready", ch_ready, 4'b1000);
      cyc(1'b0, 4'b1000, 4'b1000, '0);
      check("t4_no_match", det_valid, 0);
      cyc(1'b0, 4'b1000, 4'b1000, '0);
      cyc(1'b0, 4'b1000, 4'b0000, '0);
      cyc(1'b0, 4'b1000, 4'b1000, '0);
      cyc(1'b0, '0, '0, '0);
      check("t4_det_valid", det_valid, 1);
      check("t4_det_ch", det_ch, 3);
      check("t4_cnt", match_cnt, 4);

      // 1101101 on channel 0.
      npulse = 0;
      for (int i = 0; i < 7; i++) begin
         cyc(1'b0, 4'b0001, {3'b000, t5_b[i]}, '0);
         npulse += int'(det_valid);
      end
      cyc(1'b0, '0, '0, '0);
      npulse += int'(det_valid);
`ifdef SEQDET_OVERLAP_EN
      check("t5_pulses", npulse, 2);
      check("t5_cnt", match_cnt, 6);
`else
      check("t5_pulses", npulse, 1);
      check("t5_cnt", match_cnt, 5);
`endif
      check("t5_sat_cnt", match_cnt_s, 3);

      // Reset after a partial 110 discards it.
      cyc(1'b0, 4'b0001, 4'b0001, '0);
      cyc(1'b0, 4'b0001, 4'b0001, '0);
      cyc(1'b0, 4'b0001, 4'b0000, '0);
      cyc(1'b1, '0, '0, '0);
      check("t6_rst_cnt", match_cnt, 0);
      check("t6_rst_sat", match_cnt_s, 0);
      cyc(1'b0, 4'b0001, 4'b0001, '0);
      cyc(1'b0, '0, '0, '0);
      check("t6_no_match", det_valid, 0);
      check("t6_cnt", match_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_detect_scheduler.md
# seq_detect_scheduler

Time-multiplexed controller that shares one 1101 sequence-detection step engine among NUM_CH serial bit channels. Each cycle a round-robin arbiter grants one channel with a valid bit, loads that channel's saved FSM context, advances it by one bit, and writes it back. Completed matches are reported with the channel index. The block sits between the serial front-end receivers and the event logger, replacing NUM_CH separate detector instances.

## Interface
- NUM_CH, 4: number of input channels (2..16).
- CH_W, $clog2(NUM_CH): channel index width (derived).
- CNT_W, 16: width of the global match counter.

- clk  in  1  single clock, all state on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- ch_valid  in  NUM_CH  channel k presents a bit.
- ch_din  in  NUM_CH  serial bit for channel k.
- ch_ready  out  NUM_CH  one-hot grant; bit consumed when valid & ready.
- ch_flush  in  NUM_CH  force channel k context to S0.
- det_valid  out  1  one-cycle match pulse.
- det_ch  out  CH_W  channel that matched; valid with det_valid.
- match_cnt  out  CNT_W  total matches, saturating.

## Operation
- Context per channel: 3-bit state, S0 idle, S1 "1", S2 "11", S3 "110".
- Step function (on granted bit b): S0: b ? S1 : S0. S1: b ? S2 : S0. S2: b ? S2 : S3. S3: b ? match : S0.
- On match: det_valid asserted next cycle, det_ch = granted index, match_cnt += 1 (holds at all-ones), context written S0 (non-overlap).
- Arbiter: round-robin over ch_valid starting at pointer ptr; lowest index at or after ptr wins, wrapping. At most one ch_ready bit high; ch_ready[k] never high without ch_valid[k].
- After a grant to k, ptr = (k+1) mod NUM_CH. No valid: no grant, ptr holds.
- ch_flush[k]: context k becomes S0 on next edge. Flush and grant to k in the same cycle: flush wins, bit is consumed (ready high) and discarded, no match reported. Flush of a channel other than the granted one is independent.
- Ungranted channels' contexts are unchanged; no bits lost provided the producer holds valid/din until ready.

## Timing
- ch_ready is combinational from ch_valid and registered ptr (same cycle).
- Context write-back, ptr update: at the edge ending the grant cycle.
- det_valid/det_ch/match_cnt registered: 1 cycle after the grant cycle carrying the final 1.
- Throughput: one bit per cycle aggregate. With all channels valid, each channel is served exactly once every NUM_CH cycles.
- Reset values: ch_ready follows ch_valid with ptr=0; det_valid=0, det_ch=0, match_cnt=0, all contexts S0. Reset mid-sequence discards partial matches; a pending det_valid is cleared.

## Configuration
- SEQDET_OVERLAP_EN defined: on match, context is written S1 (trailing 1 reused), so 1101101 yields two matches.
- Undefined: context written S0, so 1101101 yields one match; 1101 1101 yields two.

## Structure
- Package seq_detect_pkg: state encodings S0..S3 (3-bit typedef), step-result struct {next_state, match}.
- Sub-module seq_step_1101: combinational step function (state, bit) -> (next_state, match), overlap behaviour selected by the macro. Arbiter, context array, and counter stay in the top.

## Test plan
- Channel 0 only, bits 1,1,0,1 on consecutive cycles: det_valid one cycle after the 4th grant, det_ch=0, match_cnt=1.
- Channels 1 and 2 interleaved, both 1101: two pulses, det_ch=1 then 2, contexts do not corrupt each other.
- All 4 valid continuously for 16 cycles: grants 0,1,2,3 repeating, each channel served 4 times.
- Channel 3 sends 1,1,0 then flush with a simultaneous granted 1: no match; subsequent 1101 matches normally.
- Bits 1101101 on channel 0: 1 match without SEQDET_OVERLAP_EN, 2 with it.
- CNT_W=2, 5 matches: match_cnt=3 and holds. Reset asserted after 110: outputs zero, a following 1 does not match.
